// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//   Parametrised VGA raster timing generator running on the system clock.
//   A pixel clock-enable is derived from a DIV-cycle divider; the column and
//   line counters advance on it. The active/sync flags pass through a
//   PIPE-deep delay line clocked by the pixel enable, so that they line up
//   with a downstream pixel pipeline. Line/frame strobes and a frame counter
//   are provided for animation and blink logic.
//
// Ports
//   clk         in   system clock
//   rst         in   asynchronous, active-low reset
//   en          in   run enable; low freezes the whole generator
//   pix_ce      out  pixel clock-enable, one clk wide
//   h_cnt       out  current column (undelayed)
//   v_cnt       out  current line (undelayed)
//   valid       out  active-area flag, delayed by PIPE pixels
//   hsync       out  horizontal sync, delayed by PIPE pixels
//   vsync       out  vertical sync, delayed by PIPE pixels
//   line_start  out  one-clk pulse after h_cnt wraps to 0
//   frame_start out  one-clk pulse after (h_cnt, v_cnt) wraps to (0,0)
//   frame_cnt   out  completed frames, modulo 256
module vga_timing_gen #(
  parameter int DIV      = 4,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int PIPE     = 1,
  parameter int CW       = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  output logic          pix_ce,
  output logic [CW-1:0] h_cnt,
  output logic [CW-1:0] v_cnt,
  output logic          valid,
  output logic          hsync,
  output logic          vsync,
  output logic          line_start,
  output logic          frame_start,
  output logic [7:0]    frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
  localparam logic [CW-1:0] H_SS     = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] H_SE     = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] V_SS     = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] V_SE     = CW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic          HS_ON    = (HS_POL != 0);
  localparam logic          VS_ON    = (VS_POL != 0);

  logic          run;
  logic [DW-1:0] div;
  logic          h_wrap;
  logic          v_wrap;
  logic          act;
  logic          hs_raw;
  logic          vs_raw;

  // The first clk edge after reset release only arms the generator, so the
  // divider phase counts from the edge after it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) run <= 1'b0;
    else      run <= 1'b1;
  end

  // Divider: phase is kept while en is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div <= '0;
    end else if (run && en) begin
      div <= (div == DIV_LAST) ? '0 : div + DW'(1);
    end
  end

  assign pix_ce = en && run && (div == DIV_LAST);
  assign h_wrap = (h_cnt == H_LAST);
  assign v_wrap = (v_cnt == V_LAST);

  // Raster counters and strobes, advanced by the pixel enable.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      frame_cnt   <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      line_start  <= pix_ce && h_wrap;
      frame_start <= pix_ce && h_wrap && v_wrap;
      if (pix_ce) begin
        h_cnt <= h_wrap ? '0 : h_cnt + CW'(1);
        if (h_wrap) begin
          v_cnt <= v_wrap ? '0 : v_cnt + CW'(1);
          if (v_wrap) frame_cnt <= frame_cnt + 8'd1;
        end
      end
    end
  end

  assign act    = (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign hs_raw = ((h_cnt >= H_SS) && (h_cnt < H_SE)) ? HS_ON : ~HS_ON;
  assign vs_raw = ((v_cnt >= V_SS) && (v_cnt < V_SE)) ? VS_ON : ~VS_ON;

  // Delay line: stage i holds the raw flags from i+1 pixel periods ago.
  generate
    if (PIPE == 0) begin : g_nodly
      assign valid = act;
      assign hsync = hs_raw;
      assign vsync = vs_raw;
    end else begin : g_dly
      logic [PIPE-1:0] vld_p;
      logic [PIPE-1:0] hs_p;
      logic [PIPE-1:0] vs_p;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          vld_p <= '0;
          hs_p  <= {PIPE{~HS_ON}};
          vs_p  <= {PIPE{~VS_ON}};
        end else if (pix_ce) begin
          vld_p[0] <= act;
          hs_p[0]  <= hs_raw;
          vs_p[0]  <= vs_raw;
          for (int i = 1; i < PIPE; i++) begin
            vld_p[i] <= vld_p[i-1];
            hs_p[i]  <= hs_p[i-1];
            vs_p[i]  <= vs_p[i-1];
          end
        end
      end

      assign valid = vld_p[PIPE-1];
      assign hsync = hs_p[PIPE-1];
      assign vsync = vs_p[PIPE-1];
    end
  endgenerate

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen
//   Scoreboard bench for vga_timing_gen on a small raster (8 x 5 pixels,
//   DIV=2, PIPE=2, positive hsync, negative vsync). The stimulus process
//   drives reset/enable one clk at a time and pushes the expected outputs,
//   derived from a count of pixel ticks since reset, into a queue; a
//   separate monitor pops and compares on every falling clk edge.
module tb_vga_timing_gen;

  localparam int DIV  = 2;
  localparam int HA   = 4;
  localparam int HF   = 1;
  localparam int HSW  = 2;
  localparam int HB   = 1;
  localparam int VA   = 2;
  localparam int VF   = 1;
  localparam int VSW  = 1;
  localparam int VB   = 1;
  localparam int HP   = 1;
  localparam int VP   = 0;
  localparam int PIPE = 2;
  localparam int CW   = 6;
  localparam int HT   = 8;   // 4+1+2+1
  localparam int VT   = 5;   // 2+1+1+1
  localparam int FT   = 40;  // pixels per frame

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          pix_ce;
  logic [CW-1:0] h_cnt;
  logic [CW-1:0] v_cnt;
  logic          valid;
  logic          hsync;
  logic          vsync;
  logic          line_start;
  logic          frame_start;
  logic [7:0]    frame_cnt;

  vga_timing_gen #(
    .DIV(DIV), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
    .HS_POL(HP), .VS_POL(VP), .PIPE(PIPE), .CW(CW)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .pix_ce(pix_ce),
    .h_cnt(h_cnt), .v_cnt(v_cnt), .valid(valid), .hsync(hsync),
    .vsync(vsync), .line_start(line_start), .frame_start(frame_start),
    .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int pce; int h; int v; int vld; int hs; int vs; int ls; int fs; int fc;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  bit   steady = 1'b0;

  // Model state: pixel ticks and enabled cycles since reset release.
  int pix = 0;
  int enc = 0;
  bit run_m = 1'b0;
  bit ls_m = 1'b0;
  bit fs_m = 1'b0;
  bit en_m = 1'b0;

  task automatic chk(input string nm, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, req, $time);
    end
  endtask

  function automatic int act_of(input int p);
    int h = p % HT;
    int v = (p / HT) % VT;
    return (h < HA && v < VA) ? 1 : 0;
  endfunction

  function automatic int hs_of(input int p);
    int h = p % HT;
    return (h >= HA + HF && h < HA + HF + HSW) ? HP : 1 - HP;
  endfunction

  function automatic int vs_of(input int p);
    int v = (p / HT) % VT;
    return (v >= VA + VF && v < VA + VF + VSW) ? VP : 1 - VP;
  endfunction

  task automatic model_reset();
    pix = 0; enc = 0; run_m = 1'b0; ls_m = 1'b0; fs_m = 1'b0;
  endtask

  task automatic model_edge(input bit r, input bit e);
    bit pe;
    if (!r) begin
      model_reset();
    end else if (!run_m) begin
      run_m = 1'b1; ls_m = 1'b0; fs_m = 1'b0;
    end else begin
      pe = e && (enc % DIV == DIV - 1);
      if (e) enc++;
      ls_m = 1'b0; fs_m = 1'b0;
      if (pe) begin
        pix++;
        ls_m = (pix % HT == 0);
        fs_m = (pix % FT == 0);
      end
    end
  endtask

  task automatic push_exp();
    exp_t x;
    x.pce = (en_m && run_m && (enc % DIV == DIV - 1)) ? 1 : 0;
    x.h   = pix % HT;
    x.v   = (pix / HT) % VT;
    if (pix >= PIPE) begin
      x.vld = act_of(pix - PIPE);
      x.hs  = hs_of(pix - PIPE);
      x.vs  = vs_of(pix - PIPE);
    end else begin
      x.vld = 0; x.hs = 1 - HP; x.vs = 1 - VP;
    end
    x.ls = ls_m;
    x.fs = fs_m;
    x.fc = (pix / FT) % 256;
    q.push_back(x);
  endtask

  task automatic step(input bit r, input bit e);
    @(negedge clk);
    #1;
    rst = r; en = e; en_m = e;
    model_edge(r, e);
    push_exp();
  endtask

  // Reset asserted between the rising and falling edge: the check at the
  // following falling edge only sees the asynchronous path.
  task automatic async_reset();
    @(negedge clk);
    #1;
    model_edge(1'b1, en_m);
    @(posedge clk);
    #2;
    rst = 1'b0;
    model_reset();
    push_exp();
  endtask

  // Monitor: scoreboard compare plus hand-computed strobe periods.
  int cyc = 0;
  int ls_last = 0;
  int fs_last = 0;
  bit ls_seen = 1'b0;
  bit fs_seen = 1'b0;

  always @(negedge clk) begin
    exp_t x;
    cyc++;
    if (q.size() > 0) begin
      x = q.pop_front();
      chk("pix_ce",      int'(pix_ce),      x.pce);
      chk("h_cnt",       int'(h_cnt),       x.h);
      chk("v_cnt",       int'(v_cnt),       x.v);
      chk("valid",       int'(valid),       x.vld);
      chk("hsync",       int'(hsync),       x.hs);
      chk("vsync",       int'(vsync),       x.vs);
      chk("line_start",  int'(line_start),  x.ls);
      chk("frame_start", int'(frame_start), x.fs);
      chk("frame_cnt",   int'(frame_cnt),   x.fc);
    end
    if (!steady) begin
      ls_seen = 1'b0;
      fs_seen = 1'b0;
    end else begin
      if (line_start) begin
        if (ls_seen) chk("line_period", cyc - ls_last, HT * DIV);
        ls_seen = 1'b1;
        ls_last = cyc;
      end
      if (frame_start) begin
        if (fs_seen) chk("frame_period", cyc - fs_last, FT * DIV);
        fs_seen = 1'b1;
        fs_last = cyc;
      end
    end
  end

  initial begin
    rst = 1'b0;
    en  = 1'b0;
    repeat (3) step(1'b0, 1'b0);
    step(1'b1, 1'b1);
    steady = 1'b1;
    repeat (199) step(1'b1, 1'b1);
    steady = 1'b0;
    repeat (10) step(1'b1, 1'b0);
    repeat (37) step(1'b1, 1'b1);
    for (int i = 0; i < 30; i++) step(1'b1, (i % 3) != 0);
    repeat (50) step(1'b1, 1'b1);
    async_reset();
    repeat (2) step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    steady = 1'b1;
    repeat (120) step(1'b1, 1'b1);
    steady = 1'b0;
    for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
    #1;
    if (q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
